branch_unit: RTL and testbench

Resolves conditional branches, conditional jumps and jump-and-link for the Tron CPU by evaluating the ALU's 5-bit flag register against a 4-bit condition code. It owns the program counter, and it redirects fetch through a small request/ready handshake with the decoder. It sits between the decoder/flag register and instruction fetch, and it consumes the flags the ALU produces.

---
 rtl/tron_pkg.sv | 39 +++
 rtl/cond_eval.sv | 46 ++++
 rtl/branch_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared Tron CPU definitions: condition codes, branch kinds, ALU flag bit
// positions and the branch unit state encoding.
package tron_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] KIND_RSVD  = 2'b00;
    localparam logic [1:0] KIND_BCOND = 2'b01;
    localparam logic [1:0] KIND_JCOND = 2'b10;
    localparam logic [1:0] KIND_JAL   = 2'b11;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2
    } bu_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: reports whether cond passes for
// the given ALU flag word. Shared by any unit that predicates on flags.
module cond_eval
    import tron_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       pass
);

    logic c;
    logic l;
    logic f;
    logic z;
    logic n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_HI: pass = l;
            COND_LS: pass = ~l;
            COND_GT: pass = n;
            COND_LE: pass = ~n;
            COND_FS: pass = f;
            COND_FC: pass = ~f;
            COND_LO: pass = ~l & ~z;
            COND_HS: pass = l | z;
            COND_LT: pass = ~n & ~z;
            COND_GE: pass = n | z;
            COND_UC: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Tron branch unit: owns the PC, resolves Bcond/Jcond/JAL requests against
// the ALU flags and redirects fetch with a one-cycle flush pulse.
module branch_unit
    import tron_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DISP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [3:0]        cond,
    input  logic [DISP_W-1:0] disp,
    input  logic [WIDTH-1:0]  target,
    input  logic [4:0]        flags,
    output logic [WIDTH-1:0]  pc,
    output logic              taken,
    output logic              flush,
    output logic              link_valid,
    output logic [WIDTH-1:0]  link_addr,
    output logic [15:0]       taken_count
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    bu_state_t         state_reg, state_next;
    logic [WIDTH-1:0]  pc_reg, pc_next;
    logic [WIDTH-1:0]  bpc_reg, bpc_next;
    logic [1:0]        bkind_reg, bkind_next;
    logic [3:0]        bcond_reg, bcond_next;
    logic [DISP_W-1:0] bdisp_reg, bdisp_next;
    logic [WIDTH-1:0]  btarget_reg, btarget_next;
    logic [WIDTH-1:0]  tgt_reg, tgt_next;
    logic              taken_reg, taken_next;
    logic              flush_reg, flush_next;
    logic              link_valid_reg, link_valid_next;
    logic [WIDTH-1:0]  link_addr_reg, link_addr_next;
    logic [15:0]       taken_count_reg, taken_count_next;

    logic              cond_pass;
    logic [WIDTH-1:0]  disp_ext;
    logic              accept;

    cond_eval u_cond_eval (
        .cond  (bcond_reg),
        .flags (flags),
        .pass  (cond_pass)
    );

    // Sign-extend the captured displacement up to the PC width.
    assign disp_ext[DISP_W-1:0] = bdisp_reg;
    generate
        for (genvar gi = DISP_W; gi < WIDTH; gi++) begin : g_sext
            assign disp_ext[gi] = bdisp_reg[DISP_W-1];
        end
    endgenerate

    assign accept = req_valid && (req_kind != KIND_RSVD);

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        bpc_next         = bpc_reg;
        bkind_next       = bkind_reg;
        bcond_next       = bcond_reg;
        bdisp_next       = bdisp_reg;
        btarget_next     = btarget_reg;
        tgt_next         = tgt_reg;
        taken_next       = 1'b0;
        flush_next       = 1'b0;
        link_valid_next  = 1'b0;
        link_addr_next   = link_addr_reg;
        taken_count_next = taken_count_reg;

        case (state_reg)
            ST_IDLE: begin
                // A request outranks a sequential advance in the same cycle.
                if (accept) begin
                    bpc_next     = pc_reg;
                    bkind_next   = req_kind;
                    bcond_next   = cond;
                    bdisp_next   = disp;
                    btarget_next = target;
                    state_next   = ST_RESOLVE;
                end else if (pc_en) begin
                    pc_next = pc_reg + PC_ONE;
                end
            end
            ST_RESOLVE: begin
                if ((bkind_reg == KIND_JAL) || cond_pass) begin
                    taken_next = 1'b1;
                    if (taken_count_reg != 16'hFFFF) begin
                        taken_count_next = taken_count_reg + 16'd1;
                    end
                    tgt_next   = (bkind_reg == KIND_BCOND) ? (bpc_reg + disp_ext)
                                                           : btarget_reg;
                    state_next = ST_REDIRECT;
                end else begin
                    pc_next    = bpc_reg + PC_ONE;
                    state_next = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                pc_next    = tgt_reg;
                flush_next = 1'b1;
                if (bkind_reg == KIND_JAL) begin
                    link_valid_next = 1'b1;
                    link_addr_next  = bpc_reg + PC_ONE;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            bpc_reg         <= '0;
            bkind_reg       <= KIND_RSVD;
            bcond_reg       <= COND_EQ;
            bdisp_reg       <= '0;
            btarget_reg     <= '0;
            tgt_reg         <= '0;
            taken_reg       <= 1'b0;
            flush_reg       <= 1'b0;
            link_valid_reg  <= 1'b0;
            link_addr_reg   <= '0;
            taken_count_reg <= 16'h0000;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            bpc_reg         <= bpc_next;
            bkind_reg       <= bkind_next;
            bcond_reg       <= bcond_next;
            bdisp_reg       <= bdisp_next;
            btarget_reg     <= btarget_next;
            tgt_reg         <= tgt_next;
            taken_reg       <= taken_next;
            flush_reg       <= flush_next;
            link_valid_reg  <= link_valid_next;
            link_addr_reg   <= link_addr_next;
            taken_count_reg <= taken_count_next;
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign pc          = pc_reg;
    assign taken       = taken_reg;
    assign flush       = flush_reg;
    assign link_valid  = link_valid_reg;
    assign link_addr   = link_addr_reg;
    assign taken_count = taken_count_reg;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a table of branch vectors plus hand-written
// sequences for reset-in-flight and taken_count saturation.
module tb_branch_unit;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] target;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic        taken;
    logic        flush;
    logic        link_valid;
    logic [15:0] link_addr;
    logic [15:0] taken_count;

    int checks;
    int errors;
    logic [15:0] cur_pc;
    logic [15:0] exp_count;

    branch_unit #(.WIDTH(16), .DISP_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_en       (pc_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .cond        (cond),
        .disp        (disp),
        .target      (target),
        .flags       (flags),
        .pc          (pc),
        .taken       (taken),
        .flush       (flush),
        .link_valid  (link_valid),
        .link_addr   (link_addr),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] start;
        logic [1:0]  kind;
        logic [3:0]  cnd;
        logic [7:0]  dsp;
        logic [15:0] tgt;
        logic [4:0]  flg;
        logic        exp_taken;
        logic [15:0] exp_pc;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_branch(input logic [1:0] kind, input logic [3:0] cnd, input logic [7:0] dsp,
                             input logic [15:0] tgt, input logic [4:0] flg,
                             input logic exp_taken, input logic [15:0] exp_pc, input string name);
        logic [15:0] start;
        start = cur_pc;
        @(negedge clk);
        check({name, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_kind  = kind;
        cond      = cnd;
        disp      = dsp;
        target    = tgt;
        flags     = flg;
        pc_en     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        pc_en     = 1'b0;
        check({name, ".pc_hold"}, {16'd0, pc}, {16'd0, start});
        check({name, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, ".taken"}, {31'd0, taken}, {31'd0, exp_taken});
        check({name, ".no_flush_e1"}, {31'd0, flush}, 32'd0);
        if (exp_taken) begin
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            check({name, ".count"}, {16'd0, taken_count}, {16'd0, exp_count});
            @(posedge clk);
            @(negedge clk);
            check({name, ".flush"}, {31'd0, flush}, 32'd1);
            check({name, ".taken_drop"}, {31'd0, taken}, 32'd0);
            check({name, ".pc_tgt"}, {16'd0, pc}, {16'd0, exp_pc});
            check({name, ".link_valid"}, {31'd0, link_valid}, {31'd0, (kind == 2'b11)});
            if (kind == 2'b11) check({name, ".link_addr"}, {16'd0, link_addr}, {16'd0, start + 16'd1});
        end else begin
            check({name, ".pc_seq"}, {16'd0, pc}, {16'd0, exp_pc});
            check({name, ".count"}, {16'd0, taken_count}, {16'd0, exp_count});
        end
        check({name, ".ready_again"}, {31'd0, req_ready}, 32'd1);
        $display("txn %s: kind=%0d cond=%0h start=%04h taken=%0d pc=%04h count=%04h",
                 name, kind, cnd, start, taken, pc, taken_count);
        cur_pc = exp_pc;
    endtask

    task automatic goto_pc(input logic [15:0] addr);
        do_branch(2'b10, 4'hE, 8'h00, addr, 5'b00000, 1'b1, addr, "goto");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 16'h0000;
        reset     = 1'b1;
        pc_en     = 1'b0;
        req_valid = 1'b0;
        req_kind  = 2'b00;
        cond      = 4'h0;
        disp      = 8'h00;
        target    = 16'h0000;
        flags     = 5'b00000;

        //           start     kind   cond  disp   target    flags     tk    exp_pc
        vecs[0]  = '{16'h0010, 2'b01, 4'h0, 8'hFC, 16'h0000, 5'b01000, 1'b1, 16'h000C};
        vecs[1]  = '{16'h0010, 2'b01, 4'h0, 8'hFC, 16'h0000, 5'b00000, 1'b0, 16'h0011};
        vecs[2]  = '{16'h0020, 2'b11, 4'h0, 8'h00, 16'h0100, 5'b00000, 1'b1, 16'h0100};
        vecs[3]  = '{16'h0030, 2'b11, 4'hF, 8'h00, 16'h0200, 5'b00000, 1'b1, 16'h0200};
        vecs[4]  = '{16'hFFFF, 2'b01, 4'hE, 8'h02, 16'h0000, 5'b00000, 1'b1, 16'h0001};
        vecs[5]  = '{16'h0040, 2'b01, 4'hF, 8'h10, 16'h0000, 5'b11111, 1'b0, 16'h0041};
        vecs[6]  = '{16'h0050, 2'b10, 4'hA, 8'h00, 16'h1234, 5'b00000, 1'b1, 16'h1234};
        vecs[7]  = '{16'h0050, 2'b10, 4'hA, 8'h00, 16'h1234, 5'b00010, 1'b0, 16'h0051};
        vecs[8]  = '{16'h0060, 2'b01, 4'hB, 8'h7F, 16'h0000, 5'b01000, 1'b1, 16'h00DF};
        vecs[9]  = '{16'h0070, 2'b01, 4'hD, 8'h80, 16'h0000, 5'b00000, 1'b0, 16'h0071};
        vecs[10] = '{16'h0080, 2'b01, 4'h2, 8'h80, 16'h0000, 5'b00001, 1'b1, 16'h0000};
        vecs[11] = '{16'h0090, 2'b01, 4'h6, 8'h05, 16'h0000, 5'b10000, 1'b1, 16'h0095};
        vecs[12] = '{16'h00A0, 2'b01, 4'hC, 8'h05, 16'h0000, 5'b10000, 1'b0, 16'h00A1};
        vecs[13] = '{16'h00B0, 2'b01, 4'h1, 8'h01, 16'h0000, 5'b00000, 1'b1, 16'h00B1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.pc", {16'd0, pc}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.taken", {31'd0, taken}, 32'd0);
        check("rst.flush", {31'd0, flush}, 32'd0);
        check("rst.link_valid", {31'd0, link_valid}, 32'd0);
        check("rst.link_addr", {16'd0, link_addr}, 32'd0);
        check("rst.count", {16'd0, taken_count}, 32'd0);

        pc_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("seq.pc", {16'd0, pc}, i);
            check("seq.ready", {31'd0, req_ready}, 32'd1);
            $display("txn seq: pc=%04h", pc);
        end
        pc_en = 1'b0;
        check("seq.count", {16'd0, taken_count}, 32'd0);
        cur_pc = 16'h0004;

        // Reserved kind must not be accepted.
        @(negedge clk);
        req_valid = 1'b1;
        req_kind  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rsvd.pc", {16'd0, pc}, {16'd0, cur_pc});
        check("rsvd.ready", {31'd0, req_ready}, 32'd1);
        $display("txn rsvd: pc=%04h ready=%0d", pc, req_ready);

        for (int v = 0; v < NVEC; v++) begin
            goto_pc(vecs[v].start);
            do_branch(vecs[v].kind, vecs[v].cnd, vecs[v].dsp, vecs[v].tgt, vecs[v].flg,
                      vecs[v].exp_taken, vecs[v].exp_pc, $sformatf("vec%0d", v));
        end

        // Reset while a taken Jcond sits in RESOLVE.
        @(negedge clk);
        req_valid = 1'b1;
        req_kind  = 2'b10;
        cond      = 4'hE;
        target    = 16'h0300;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid.taken", {31'd0, taken}, 32'd0);
        check("rstmid.flush", {31'd0, flush}, 32'd0);
        check("rstmid.pc", {16'd0, pc}, 32'd0);
        check("rstmid.ready", {31'd0, req_ready}, 32'd1);
        check("rstmid.count", {16'd0, taken_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid.flush_after", {31'd0, flush}, 32'd0);
        check("rstmid.pc_after", {16'd0, pc}, 32'd0);
        $display("txn rstmid: pc=%04h taken=%0d flush=%0d", pc, taken, flush);
        cur_pc    = 16'h0000;
        exp_count = 16'h0000;

        // Saturation: preload the counter just below the ceiling.
        @(negedge clk);
        force dut.taken_count_reg = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.taken_count_reg;
        exp_count = 16'hFFFE;
        goto_pc(16'h0010);
        goto_pc(16'h0020);
        goto_pc(16'h0030);
        check("sat.final", {16'd0, taken_count}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end, %0d checks done", checks);
        $fatal(1);
    end

endmodule
